sys_cmd_decoder: RTL and testbench
==================================

SYS_CMD_DECODER -- requirements
Module: sys_cmd_decoder

Interface
REQ-001 SHALL have parameters: DATA_WIDTH, 8, byte width; ADDR, 4, register-file address width; ALU_OUT_WIDTH, 16, ALU result width.
REQ-002 SHALL have one clock and an asynchronous, active-low reset, with ports listed below.
REQ-003 CLK  in  1  system clock; every flop rises on CLK.
REQ-004 RST  in  1  asynchronous active-low reset.
REQ-005 RX_P_DATA  in  DATA_WIDTH  received UART byte.
REQ-006 RX_D_VLD  in  1  one-cycle pulse, RX_P_DATA valid.
REQ-007 RF_RD_DATA  in  DATA_WIDTH / RF_RD_DATA_VLD  in  1  register-file read data and its valid pulse.
REQ-008 ALU_OUT  in  ALU_OUT_WIDTH / ALU_OUT_VLD  in  1  ALU result and its valid pulse.
REQ-009 FIFO_FULL  in  1  TX FIFO full; blocks pushes.
REQ-010 RF_ADDR  out  ADDR / RF_WR_DATA  out  DATA_WIDTH / RF_WR_EN, RF_RD_EN  out  1  register-file access.
REQ-011 ALU_EN  out  1 / ALU_FUN  out  4 / CLK_GATE_EN  out  1  ALU control.
REQ-012 TX_P_DATA  out  DATA_WIDTH / TX_D_VLD  out  1  response byte push to TX FIFO.

Function
REQ-013 SHALL decode command frames: 0xAA addr data = RF write; 0xBB addr = RF read; 0xCC opA opB fun = ALU with operands; 0xDD fun = ALU without operands.
REQ-014 SHALL implement states IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OPA, OPB, FUN, ALU_WAIT, SEND_RD, SEND_LSB, SEND_MSB.
REQ-015 In IDLE, the opcode on RX_D_VLD SHALL select the next state: AA->WR_ADDR, BB->RD_ADDR, CC->OPA, DD->FUN. Any other byte SHALL be dropped, and the block SHALL stay in IDLE.
REQ-016 SHALL advance one state per RX_D_VLD pulse in byte-collecting states. Bytes arriving in RD_WAIT, ALU_WAIT or SEND_* states SHALL be dropped.
REQ-017 Write: one cycle after the data byte's RX_D_VLD, RF_WR_EN SHALL pulse for exactly 1 cycle, with RF_ADDR=captured addr and RF_WR_DATA=data. The block SHALL then return to IDLE; no response is sent.
REQ-018 Read: one cycle after the addr byte, RF_RD_EN SHALL pulse for 1 cycle and the block SHALL enter RD_WAIT.
REQ-019 In RD_WAIT, on RF_RD_DATA_VLD the block SHALL capture RF_RD_DATA and go to SEND_RD.
REQ-020 CC: opA SHALL be written to address 0 and opB to address 1, each via a 1-cycle RF_WR_EN pulse one cycle after its byte.
REQ-021 CC/DD: one cycle after the fun byte, ALU_FUN SHALL be set to fun[3:0], and ALU_EN and CLK_GATE_EN SHALL assert and hold through ALU_WAIT.
REQ-022 In ALU_WAIT, on ALU_OUT_VLD the block SHALL capture the 16-bit ALU_OUT, deassert ALU_EN and CLK_GATE_EN the next cycle, and go to SEND_LSB.
REQ-023 In SEND_* states, TX_D_VLD SHALL pulse for 1 cycle with TX_P_DATA valid only when FIFO_FULL=0. While FIFO_FULL=1, the block SHALL hold state, with no pulse and no data loss.
REQ-024 Send order for ALU: LSB (ALU_OUT[7:0]) then MSB (ALU_OUT[15:8]); always 2 bytes, even if MSB=0. SEND_RD SHALL send 1 byte. All SHALL return to IDLE after the last push.
REQ-025 Minimum gap between consecutive TX_D_VLD pulses SHALL be 1 cycle of 0. If FIFO_FULL rises in the same cycle as the push decision, the block SHALL hold.
REQ-026 RF_WR_EN and RF_RD_EN SHALL never be high in the same cycle. At most one access per cycle.
REQ-027 Outputs SHALL be registered, with no combinational path from inputs to outputs.

Reset
REQ-028 RST=0 SHALL force, asynchronously, state=IDLE and all outputs and internal capture registers to 0, including mid-frame and mid-ALU_WAIT. A partially received frame SHALL be discarded.
REQ-029 After RST is released, the first RX_D_VLD SHALL be treated as an opcode.

Verification
REQ-030 Bytes AA,04,5A -> single RF_WR_EN pulse with RF_ADDR=4, RF_WR_DATA=0x5A; no TX_D_VLD.
REQ-031 Bytes BB,04; RF returns 0x5A -> one RF_RD_EN pulse, RF_ADDR=4, then one TX_D_VLD with TX_P_DATA=0x5A.
REQ-032 Bytes CC,09,07,01; ALU_OUT=0x0002 -> writes (0,0x09), (1,0x07), ALU_FUN=1, ALU_EN high until VLD, then TX 0x02 then 0x00.
REQ-033 Bytes DD,02; ALU_OUT=0x7387 with FIFO_FULL=1 for 5 cycles at SEND_LSB -> no push while full, then TX 0x87, 0x73.
REQ-034 Byte 0x55 in IDLE, then AA,01,0F -> 0x55 ignored; write (1,0x0F) occurs.
REQ-035 RST pulsed after CC,09 -> all outputs 0, state IDLE; a following DD,00 with ALU_OUT=0x0158 -> TX 0x58, 0x01.

Source files
------------

// File: rtl/sys_cmd_decoder_if.sv
// Decoder-side bundle: UART RX bytes, register-file port, ALU control/result and TX FIFO push.
// master = the decoder, slave = the surrounding system (RX, RF, ALU, TX FIFO).
interface sys_cmd_decoder_if #(
   parameter int DATA_WIDTH    = 8,
   parameter int ADDR          = 4,
   parameter int ALU_OUT_WIDTH = 16
);
   logic [DATA_WIDTH-1:0]    RX_P_DATA;
   logic                     RX_D_VLD;
   logic [DATA_WIDTH-1:0]    RF_RD_DATA;
   logic                     RF_RD_DATA_VLD;
   logic [ALU_OUT_WIDTH-1:0] ALU_OUT;
   logic                     ALU_OUT_VLD;
   logic                     FIFO_FULL;
   logic [ADDR-1:0]          RF_ADDR;
   logic [DATA_WIDTH-1:0]    RF_WR_DATA;
   logic                     RF_WR_EN;
   logic                     RF_RD_EN;
   logic                     ALU_EN;
   logic [3:0]               ALU_FUN;
   logic                     CLK_GATE_EN;
   logic [DATA_WIDTH-1:0]    TX_P_DATA;
   logic                     TX_D_VLD;

   modport master (
      input  RX_P_DATA, RX_D_VLD, RF_RD_DATA, RF_RD_DATA_VLD, ALU_OUT, ALU_OUT_VLD, FIFO_FULL,
      output RF_ADDR, RF_WR_DATA, RF_WR_EN, RF_RD_EN, ALU_EN, ALU_FUN, CLK_GATE_EN,
             TX_P_DATA, TX_D_VLD
   );

   modport slave (
      output RX_P_DATA, RX_D_VLD, RF_RD_DATA, RF_RD_DATA_VLD, ALU_OUT, ALU_OUT_VLD, FIFO_FULL,
      input  RF_ADDR, RF_WR_DATA, RF_WR_EN, RF_RD_EN, ALU_EN, ALU_FUN, CLK_GATE_EN,
             TX_P_DATA, TX_D_VLD
   );
endinterface

// File: rtl/sys_cmd_decoder.sv
// UART command-frame decoder driving RF/ALU; all outputs registered, 1 cycle after the triggering byte.
// TX pushes stall while FIFO_FULL is high and are spaced by at least one idle cycle.
module sys_cmd_decoder #(
   parameter int DATA_WIDTH    = 8,
   parameter int ADDR          = 4,
   parameter int ALU_OUT_WIDTH = 16
) (
   input  logic              CLK,
   input  logic              RST,
   sys_cmd_decoder_if.master bus
);
   localparam logic [DATA_WIDTH-1:0] OP_WR     = DATA_WIDTH'(8'hAA);
   localparam logic [DATA_WIDTH-1:0] OP_RD     = DATA_WIDTH'(8'hBB);
   localparam logic [DATA_WIDTH-1:0] OP_ALU_OP = DATA_WIDTH'(8'hCC);
   localparam logic [DATA_WIDTH-1:0] OP_ALU    = DATA_WIDTH'(8'hDD);

   typedef enum logic [3:0] {
      IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OPA, OPB, FUN,
      ALU_WAIT, SEND_RD, SEND_LSB, SEND_MSB
   } state_t;

   state_t                   state_q;
   logic [ADDR-1:0]          rf_addr_q;
   logic [DATA_WIDTH-1:0]    rf_wr_data_q;
   logic                     rf_wr_en_q;
   logic                     rf_rd_en_q;
   logic                     alu_en_q;
   logic [3:0]               alu_fun_q;
   logic                     clk_gate_en_q;
   logic [DATA_WIDTH-1:0]    tx_data_q;
   logic                     tx_vld_q;
   logic [DATA_WIDTH-1:0]    rd_data_q;
   logic [ALU_OUT_WIDTH-1:0] alu_res_q;
   logic                     can_push;

   // A push just issued blocks the next one, which forces the idle gap between TX pulses.
   assign can_push = !bus.FIFO_FULL && !tx_vld_q;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q       <= IDLE;
         rf_addr_q     <= '0;
         rf_wr_data_q  <= '0;
         rf_wr_en_q    <= 1'b0;
         rf_rd_en_q    <= 1'b0;
         alu_en_q      <= 1'b0;
         alu_fun_q     <= '0;
         clk_gate_en_q <= 1'b0;
         tx_data_q     <= '0;
         tx_vld_q      <= 1'b0;
         rd_data_q     <= '0;
         alu_res_q     <= '0;
      end else begin
         rf_wr_en_q <= 1'b0;
         rf_rd_en_q <= 1'b0;
         tx_vld_q   <= 1'b0;
         case (state_q)
            IDLE: if (bus.RX_D_VLD) begin
               case (bus.RX_P_DATA)
                  OP_WR:     state_q <= WR_ADDR;
                  OP_RD:     state_q <= RD_ADDR;
                  OP_ALU_OP: state_q <= OPA;
                  OP_ALU:    state_q <= FUN;
                  default:   state_q <= IDLE;
               endcase
            end
            WR_ADDR: if (bus.RX_D_VLD) begin
               rf_addr_q <= bus.RX_P_DATA[ADDR-1:0];
               state_q   <= WR_DATA;
            end
            WR_DATA: if (bus.RX_D_VLD) begin
               rf_wr_data_q <= bus.RX_P_DATA;
               rf_wr_en_q   <= 1'b1;
               state_q      <= IDLE;
            end
            RD_ADDR: if (bus.RX_D_VLD) begin
               rf_addr_q  <= bus.RX_P_DATA[ADDR-1:0];
               rf_rd_en_q <= 1'b1;
               state_q    <= RD_WAIT;
            end
            RD_WAIT: if (bus.RF_RD_DATA_VLD) begin
               rd_data_q <= bus.RF_RD_DATA;
               state_q   <= SEND_RD;
            end
            // Operands land at fixed RF addresses 0 and 1 where the ALU picks them up.
            OPA: if (bus.RX_D_VLD) begin
               rf_addr_q    <= '0;
               rf_wr_data_q <= bus.RX_P_DATA;
               rf_wr_en_q   <= 1'b1;
               state_q      <= OPB;
            end
            OPB: if (bus.RX_D_VLD) begin
               rf_addr_q    <= ADDR'(1);
               rf_wr_data_q <= bus.RX_P_DATA;
               rf_wr_en_q   <= 1'b1;
               state_q      <= FUN;
            end
            FUN: if (bus.RX_D_VLD) begin
               alu_fun_q     <= bus.RX_P_DATA[3:0];
               alu_en_q      <= 1'b1;
               clk_gate_en_q <= 1'b1;
               state_q       <= ALU_WAIT;
            end
            ALU_WAIT: if (bus.ALU_OUT_VLD) begin
               alu_res_q     <= bus.ALU_OUT;
               alu_en_q      <= 1'b0;
               clk_gate_en_q <= 1'b0;
               state_q       <= SEND_LSB;
            end
            SEND_RD: if (can_push) begin
               tx_data_q <= rd_data_q;
               tx_vld_q  <= 1'b1;
               state_q   <= IDLE;
            end
            SEND_LSB: if (can_push) begin
               tx_data_q <= alu_res_q[DATA_WIDTH-1:0];
               tx_vld_q  <= 1'b1;
               state_q   <= SEND_MSB;
            end
            SEND_MSB: if (can_push) begin
               tx_data_q <= alu_res_q[2*DATA_WIDTH-1:DATA_WIDTH];
               tx_vld_q  <= 1'b1;
               state_q   <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.RF_ADDR     = rf_addr_q;
   assign bus.RF_WR_DATA  = rf_wr_data_q;
   assign bus.RF_WR_EN    = rf_wr_en_q;
   assign bus.RF_RD_EN    = rf_rd_en_q;
   assign bus.ALU_EN      = alu_en_q;
   assign bus.ALU_FUN     = alu_fun_q;
   assign bus.CLK_GATE_EN = clk_gate_en_q;
   assign bus.TX_P_DATA   = tx_data_q;
   assign bus.TX_D_VLD    = tx_vld_q;
endmodule

// File: tb/tb_sys_cmd_decoder.sv
// Directed frames for sys_cmd_decoder; RF writes/reads and TX bytes are matched against queued expectations.
`timescale 1ns/1ps
module tb_sys_cmd_decoder;
   logic CLK = 1'b0;
   logic RST = 1'b0;
   always #5 CLK = ~CLK;

   sys_cmd_decoder_if #(.DATA_WIDTH(8), .ADDR(4), .ALU_OUT_WIDTH(16)) bus ();

   sys_cmd_decoder #(.DATA_WIDTH(8), .ADDR(4), .ALU_OUT_WIDTH(16)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   int errors = 0;
   int checks = 0;

   logic [7:0]  tx_q[$];
   logic [11:0] wr_q[$];
   logic [3:0]  rd_q[$];

   logic prev_rx = 1'b0, prev_full = 1'b0, prev_tx = 1'b0, prev_wr = 1'b0;

   always @(negedge CLK) begin
      if (RST) begin
         if (bus.RF_WR_EN || bus.RF_RD_EN) begin
            checks++;
            assert (!(bus.RF_WR_EN && bus.RF_RD_EN)) else begin
               errors++; $error("FAIL rf_excl observed wr=%b rd=%b expected one", bus.RF_WR_EN, bus.RF_RD_EN);
            end
            checks++;
            assert (prev_rx === 1'b1) else begin
               errors++; $error("FAIL rf_timing observed no byte in prior cycle expected byte one cycle before");
            end
         end
         if (bus.RF_WR_EN) begin
            checks++;
            assert (!prev_wr && wr_q.size() != 0) else begin
               errors++; $error("FAIL rf_wr_pulse observed prev_wr=%b pending=%0d expected single expected pulse", prev_wr, wr_q.size());
            end
            if (wr_q.size() != 0) begin
               logic [11:0] exp_wr;
               exp_wr = wr_q.pop_front();
               checks++;
               assert ({bus.RF_ADDR, bus.RF_WR_DATA} === exp_wr) else begin
                  errors++; $error("FAIL rf_wr observed addr=%0h data=%02h expected addr=%0h data=%02h",
                                   bus.RF_ADDR, bus.RF_WR_DATA, exp_wr[11:8], exp_wr[7:0]);
               end
            end
         end
         if (bus.RF_RD_EN) begin
            checks++;
            assert (rd_q.size() != 0) else begin
               errors++; $error("FAIL rf_rd_unexpected observed addr=%0h expected no read", bus.RF_ADDR);
            end
            if (rd_q.size() != 0) begin
               logic [3:0] exp_rd;
               exp_rd = rd_q.pop_front();
               checks++;
               assert (bus.RF_ADDR === exp_rd) else begin
                  errors++; $error("FAIL rf_rd_addr observed %0h expected %0h", bus.RF_ADDR, exp_rd);
               end
            end
         end
         if (bus.TX_D_VLD) begin
            checks++;
            assert (!prev_tx && !prev_full) else begin
               errors++; $error("FAIL tx_gap_full observed prev_tx=%b prev_full=%b expected 0/0", prev_tx, prev_full);
            end
            checks++;
            assert (tx_q.size() != 0) else begin
               errors++; $error("FAIL tx_unexpected observed %02h expected no push", bus.TX_P_DATA);
            end
            if (tx_q.size() != 0) begin
               logic [7:0] exp_tx;
               exp_tx = tx_q.pop_front();
               checks++;
               assert (bus.TX_P_DATA === exp_tx) else begin
                  errors++; $error("FAIL tx_data observed %02h expected %02h", bus.TX_P_DATA, exp_tx);
               end
            end
         end
      end
      prev_rx   <= bus.RX_D_VLD;
      prev_full <= bus.FIFO_FULL;
      prev_tx   <= bus.TX_D_VLD;
      prev_wr   <= bus.RF_WR_EN;
   end

   task automatic send_byte(input logic [7:0] b);
      @(posedge CLK); #1;
      bus.RX_P_DATA = b;
      bus.RX_D_VLD  = 1'b1;
      @(posedge CLK); #1;
      bus.RX_D_VLD  = 1'b0;
   endtask

   task automatic check_outputs_zero(input string tag);
      logic [28:0] outs;
      outs = {bus.RF_ADDR, bus.RF_WR_DATA, bus.RF_WR_EN, bus.RF_RD_EN, bus.ALU_EN, bus.ALU_FUN,
              bus.CLK_GATE_EN, bus.TX_P_DATA, bus.TX_D_VLD};
      checks++;
      assert (outs === 29'd0) else begin
         errors++; $error("FAIL %s observed outputs=%08h expected 0", tag, outs);
      end
   endtask

   // Call right after the fun byte: ALU_EN must already be up, then the result is returned.
   task automatic alu_cycle(input logic [3:0] fun, input logic [15:0] res, input int full_cycles);
      checks++;
      assert (bus.ALU_EN === 1'b1 && bus.CLK_GATE_EN === 1'b1) else begin
         errors++; $error("FAIL alu_en_rise observed en=%b gate=%b expected 1/1", bus.ALU_EN, bus.CLK_GATE_EN);
      end
      checks++;
      assert (bus.ALU_FUN === fun) else begin
         errors++; $error("FAIL alu_fun observed %0h expected %0h", bus.ALU_FUN, fun);
      end
      repeat (3) @(posedge CLK);
      #1;
      checks++;
      assert (bus.ALU_EN === 1'b1 && bus.CLK_GATE_EN === 1'b1) else begin
         errors++; $error("FAIL alu_en_hold observed en=%b gate=%b expected 1/1", bus.ALU_EN, bus.CLK_GATE_EN);
      end
      if (full_cycles > 0) bus.FIFO_FULL = 1'b1;
      bus.ALU_OUT     = res;
      bus.ALU_OUT_VLD = 1'b1;
      @(posedge CLK); #1;
      bus.ALU_OUT_VLD = 1'b0;
      checks++;
      assert (bus.ALU_EN === 1'b0 && bus.CLK_GATE_EN === 1'b0) else begin
         errors++; $error("FAIL alu_en_fall observed en=%b gate=%b expected 0/0", bus.ALU_EN, bus.CLK_GATE_EN);
      end
      for (int i = 0; i < full_cycles; i++) begin
         @(posedge CLK); #1;
         checks++;
         assert (bus.TX_D_VLD === 1'b0) else begin
            errors++; $error("FAIL tx_while_full observed %b expected 0 (cycle %0d)", bus.TX_D_VLD, i);
         end
      end
      bus.FIFO_FULL = 1'b0;
   endtask

   task automatic drain(input string tag);
      int n = 0;
      while ((tx_q.size() != 0 || wr_q.size() != 0 || rd_q.size() != 0) && n < 60) begin
         @(negedge CLK); n++;
      end
      repeat (4) @(negedge CLK);
      checks++;
      assert (tx_q.size() == 0 && wr_q.size() == 0 && rd_q.size() == 0) else begin
         errors++; $error("FAIL %s_drain observed pending tx=%0d wr=%0d rd=%0d expected 0",
                          tag, tx_q.size(), wr_q.size(), rd_q.size());
      end
   endtask

   initial begin
      bus.RX_P_DATA = '0;  bus.RX_D_VLD = 1'b0;
      bus.RF_RD_DATA = '0; bus.RF_RD_DATA_VLD = 1'b0;
      bus.ALU_OUT = '0;    bus.ALU_OUT_VLD = 1'b0;
      bus.FIFO_FULL = 1'b0;
      #12;
      check_outputs_zero("reset_state");
      @(negedge CLK); RST = 1'b1;

      // Register write
      wr_q.push_back({4'h4, 8'h5A});
      send_byte(8'hAA); send_byte(8'h04); send_byte(8'h5A);
      drain("write");

      // Register read, with a stray byte during RD_WAIT that must be dropped
      rd_q.push_back(4'h4);
      tx_q.push_back(8'h5A);
      send_byte(8'hBB); send_byte(8'h04);
      send_byte(8'hCC);
      @(posedge CLK); #1;
      bus.RF_RD_DATA = 8'h5A; bus.RF_RD_DATA_VLD = 1'b1;
      @(posedge CLK); #1;
      bus.RF_RD_DATA_VLD = 1'b0;
      drain("read");

      // ALU with operands
      wr_q.push_back({4'h0, 8'h09});
      wr_q.push_back({4'h1, 8'h07});
      tx_q.push_back(8'h02); tx_q.push_back(8'h00);
      send_byte(8'hCC); send_byte(8'h09); send_byte(8'h07); send_byte(8'h01);
      alu_cycle(4'h1, 16'h0002, 0);
      drain("alu_ops");

      // ALU without operands, FIFO full for 5 cycles at SEND_LSB
      tx_q.push_back(8'h87); tx_q.push_back(8'h73);
      send_byte(8'hDD); send_byte(8'h02);
      alu_cycle(4'h2, 16'h7387, 5);
      drain("alu_full");

      // Unknown opcode dropped, then a write
      wr_q.push_back({4'h1, 8'h0F});
      send_byte(8'h55);
      send_byte(8'hAA); send_byte(8'h01); send_byte(8'h0F);
      drain("bad_opcode");

      // Reset mid-frame discards the partial CC frame
      wr_q.push_back({4'h0, 8'h09});
      send_byte(8'hCC); send_byte(8'h09);
      @(negedge CLK); #2;
      RST = 1'b0;
      #1;
      check_outputs_zero("mid_frame_reset");
      @(negedge CLK); @(negedge CLK);
      RST = 1'b1;
      tx_q.push_back(8'h58); tx_q.push_back(8'h01);
      send_byte(8'hDD); send_byte(8'h00);
      alu_cycle(4'h0, 16'h0158, 0);
      drain("after_reset");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
